piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//   Parallel-in/serial-out stage that generates the one-bit stream j consumed by
//   the 10110 sequence detectors (mealy/moore). Accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out one bit per clock.
//   Supports gapless back-to-back words, so the detectors see continuous streams.
// PARAMETERS
//   WIDTH      5   word length in bits; legal range >= 2
//   MSB_FIRST  1   1: din[WIDTH-1] is sent first; 0: din[0] is sent first
// PORTS
//   clk        in   1      single clock; all state changes on the rising edge
//   rst        in   1      asynchronous, active-low reset (rst==0 resets)
//   din_valid  in   1      upstream has a word on din
//   din        in   WIDTH  parallel word; sampled only on accept
//   din_ready  out  1      stage can accept a word this cycle
//   j          out  1      serial bit to detector; 0 whenever j_valid==0
//   j_valid    out  1      j carries a data bit this cycle
//   done       out  1      1-cycle pulse, coincident with the last bit of a word
// BEHAVIOUR
//   - Reset (rst low, asynchronous): j=0, j_valid=0, done=0, din_ready=1;
//     state=IDLE, bit counter=0, shift register=0.
//   - Accept: din_valid & din_ready at a rising edge. din is loaded into the
//     shift register. State goes to SHIFT with count 0.
//   - Latency: the first bit appears on j in the cycle after accept (registered).
//   - FSM states: IDLE, SHIFT.
//       IDLE : din_ready=1, j_valid=0, j=0. accept -> SHIFT; else stay.
//       SHIFT: j_valid=1; j = current head bit; the counter runs 0..WIDTH-1.
//              When count==WIDTH-1 (last bit): done=1 and din_ready=1.
//                accept -> reload, count=0, stay in SHIFT (no idle gap)
//                no accept -> IDLE
//              When count<WIDTH-1: din_ready=0, shift by one, count+1.
//   - din_ready is combinational from state/count; it does not depend on din_valid.
//   - din_valid while din_ready==0: ignored. Upstream holds din_valid/din until
//     accepted; no word is dropped or duplicated.
//   - Counter width $clog2(WIDTH). The counter never exceeds WIDTH-1; no wrap
//     other than the reload to 0.
//   - Shift direction: MSB_FIRST=1 shifts left and outputs bit WIDTH-1.
//     MSB_FIRST=0 shifts right and outputs bit 0. Vacated bits fill with 0.
//   - Reset mid-word: the word is aborted at once and the partial word is discarded.
//     After rst is released, the stage waits in IDLE for a new accept.
//   - din changing while not accepted has no effect on j.
// STRUCTURE
//   - Shared include state_machines_defs.vh:
//       state encodings S_IDLE=1'b0, S_SHIFT=1'b1
//       default width constant SER_WIDTH_DEF=5 (matches the 10110 pattern length)
//   - Sub-module piso_shift_reg(clk, rst, load, shift, d[WIDTH-1:0], q_bit),
//     parameterised WIDTH and MSB_FIRST, holding the data register.
//   - Top level holds the FSM, the bit counter, the handshake and the output registers.
// TESTING  (WIDTH=5, MSB_FIRST=1, unless stated)
//   1 Reset: hold rst=0 for 2 cycles -> j=0, j_valid=0, done=0, din_ready=1.
//     Assert rst mid-word -> outputs return to reset values without waiting for clk.
//   2 Single word: din=5'b10110 accepted at edge t.
//     -> j = 1,0,1,1,0 at cycles t+1..t+5, j_valid=1 for those cycles.
//     -> done=1 only at t+5. Chained to mealy10110, its w asserts on the last bit.
//   3 Back-to-back: 5'b10110 then 5'b11010, din_valid held high.
//     -> din_ready high only on the last-bit cycle.
//     -> 10 contiguous j_valid cycles carrying 1011011010; done pulses at t+5 and t+10.
//   4 Stall: din_valid pulsed during bits 2-4 with din=5'b11111.
//     -> ignored; stream unchanged. Word accepted at the next din_ready cycle.
//   5 Reset abort: rst low for 1 cycle after bit 3 of 5'b10110.
//     -> j_valid=0 immediately, IDLE; the next word starts fresh from its first bit.
//   6 LSB-first: MSB_FIRST=0, din=5'b01101 -> j = 1,0,1,1,0; done at bit 5.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// Shared constants for the serializer block: FSM encodings and default word length.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package piso_serializer_pkg;

  // FSM encodings (one bit is enough for two states)
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // Default word length; matches the 10110 pattern length the detectors look for
  localparam int SER_WIDTH_DEF = 5;

endpackage : piso_serializer_pkg

// File: rtl/piso_shift_reg.sv
// Data register for the serializer: parallel load, one-bit shift, head-bit tap.
// Latency: q_bit reflects a load or shift on the cycle after the edge.
// Backpressure: none; the owner decides when to load or shift.
module piso_shift_reg #(
  parameter int WIDTH     = 5,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: load wins over shift; vacated bit positions fill with zero
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
      end
    end
  end

  // Data register with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // The head bit is the end the register shifts toward
  assign q_bit = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];

endmodule : piso_shift_reg

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding the 10110 detectors with a one-bit stream.
// Latency: first bit of an accepted word appears on j the cycle after accept.
// Backpressure: din_ready only in IDLE or on the last bit of a word; back-to-back words are gapless.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             j,
  output logic             j_valid,
  output logic             done
);

  localparam int               CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          last_bit;
  logic          shift_en;
  logic          head_bit;

  // Last bit of the current word is on j this cycle
  assign last_bit  = (state_q == S_SHIFT) && (cnt_q == LAST);
  // Ready depends only on state/count, never on din_valid
  assign din_ready = (state_q == S_IDLE) || last_bit;
  assign accept    = din_valid && din_ready;

  // FSM and bit counter next-state; an accept on the last bit reloads without an idle gap
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          cnt_d = '0;
          if (!accept) begin
            state_d = S_IDLE;
          end
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset aborts any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_en),
    .d     (din),
    .q_bit (head_bit)
  );

  // Outputs decode registered state only, so they clear as soon as reset asserts
  assign j_valid = (state_q == S_SHIFT);
  assign j       = j_valid && head_bit;
  assign done    = last_bit;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic       din_valid;
  logic [4:0] din;
  logic       din_ready_m, j_m, j_valid_m, done_m;
  logic       din_ready_l, j_l, j_valid_l, done_l;

  int vectors    = 0;
  int miscompares = 0;

  // Expected stream of the word currently offered, first bit in position 4
  logic [4:0] cur_m, cur_l;
  // Scoreboard entries: {expected j, expected done}
  logic [1:0] sbq_m[$];
  logic [1:0] sbq_l[$];

  typedef struct {
    logic [4:0] din;
    logic [4:0] exp_m;
    logic [4:0] exp_l;
  } vec_t;
  vec_t vecs[5];

  piso_serializer #(.WIDTH(5), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .din_ready(din_ready_m), .j(j_m), .j_valid(j_valid_m), .done(done_m)
  );

  piso_serializer #(.WIDTH(5), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .din_ready(din_ready_l), .j(j_l), .j_valid(j_valid_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  // Scoreboard monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      sbq_m.delete();
      sbq_l.delete();
      check("rst_jv_m", j_valid_m, 1'b0);
      check("rst_rdy_m", din_ready_m, 1'b1);
      check("rst_jv_l", j_valid_l, 1'b0);
    end else begin
      logic [1:0] e;
      if (sbq_m.size() > 0) begin
        e = sbq_m.pop_front();
        check("jv_m", j_valid_m, 1'b1);
        check("j_m", j_m, e[1]);
        check("done_m", done_m, e[0]);
      end else begin
        check("jv_idle_m", j_valid_m, 1'b0);
        check("j_idle_m", j_m, 1'b0);
        check("done_idle_m", done_m, 1'b0);
      end
      check("rdy_m", din_ready_m, sbq_m.size() == 0);
      if (sbq_l.size() > 0) begin
        e = sbq_l.pop_front();
        check("jv_l", j_valid_l, 1'b1);
        check("j_l", j_l, e[1]);
        check("done_l", done_l, e[0]);
      end else begin
        check("jv_idle_l", j_valid_l, 1'b0);
        check("j_idle_l", j_l, 1'b0);
        check("done_idle_l", done_l, 1'b0);
      end
      check("rdy_l", din_ready_l, sbq_l.size() == 0);
      if (din_valid && din_ready_m)
        for (int i = 4; i >= 0; i--) sbq_m.push_back({cur_m[i], i == 0});
      if (din_valid && din_ready_l)
        for (int i = 4; i >= 0; i--) sbq_l.push_back({cur_l[i], i == 0});
    end
  end

  // Offer a word from posedge+1 until accepted; returns at the accept edge +1
  task automatic send_word(input logic [4:0] d, input logic [4:0] em, input logic [4:0] el);
    logic seen;
    seen      = 1'b0;
    din       = d;
    cur_m     = em;
    cur_l     = el;
    din_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (din_ready_m) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_timeout", seen, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (sbq_m.size() != 0 || sbq_l.size() != 0); k++) @(negedge clk);
    check("drain_m", sbq_m.size() == 0, 1'b1);
    check("drain_l", sbq_l.size() == 0, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{din: 5'b10110, exp_m: 5'b10110, exp_l: 5'b01101};
    vecs[1] = '{din: 5'b11010, exp_m: 5'b11010, exp_l: 5'b01011};
    vecs[2] = '{din: 5'b01101, exp_m: 5'b01101, exp_l: 5'b10110};
    vecs[3] = '{din: 5'b00001, exp_m: 5'b00001, exp_l: 5'b10000};
    vecs[4] = '{din: 5'b10000, exp_m: 5'b10000, exp_l: 5'b00001};

    rst = 1'b0; din_valid = 1'b0; din = '0; cur_m = '0; cur_l = '0;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    check("reset_j", j_m, 1'b0);
    check("reset_jv", j_valid_m, 1'b0);
    check("reset_done", done_m, 1'b0);
    check("reset_rdy", din_ready_m, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single word with idle cycles around it
    send_word(vecs[0].din, vecs[0].exp_m, vecs[0].exp_l);
    drain();

    // Table of words, sent back-to-back with din_valid held high
    for (int v = 0; v < 5; v++) send_word(vecs[v].din, vecs[v].exp_m, vecs[v].exp_l);
    drain();

    // Stall: valid pulsed with 11111 while busy must be ignored
    send_word(5'b10110, 5'b10110, 5'b01101);
    @(posedge clk); #1;
    din = 5'b11111; cur_m = 5'b11111; cur_l = 5'b11111; din_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din_valid = 1'b0;
    send_word(5'b11010, 5'b11010, 5'b01011);
    drain();

    // Reset abort mid-word, checked before any clock edge
    send_word(5'b10110, 5'b10110, 5'b01101);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    check("abort_pre_jv", j_valid_m, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_jv_m", j_valid_m, 1'b0);
    check("abort_j_m", j_m, 1'b0);
    check("abort_done_m", done_m, 1'b0);
    check("abort_rdy_m", din_ready_m, 1'b1);
    check("abort_jv_l", j_valid_l, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    send_word(vecs[2].din, vecs[2].exp_m, vecs[2].exp_l);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_piso_serializer
